// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the round-robin arbiter, its requesters and the FIFO.
// The master side is the arbiter; the slave side is the requesters plus FIFO status.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            ready;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req, req_data, full,
    output ready, w_en, data_in, grant_id, busy
  );

  modport slave (
    output req, req_data, full,
    input  ready, w_en, data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// One requester owns the port for up to MAX_BURST beats; full stalls beats in place.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] pick;
  logic          any_req;
  logic          req_g;
  logic          end_burst;
  int            idx;

  assign req_g = bus.req[grant_q];

  // Descending scan so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    pick    = rr_q;
    any_req = |bus.req;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[idx]) pick = GW'(idx);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    end_burst = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req_g) begin
          end_burst = 1'b1;
        end else if (!bus.full) begin
          if (beat_q == LAST_BEAT) end_burst = 1'b1;
          else                     beat_d    = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (end_burst) begin
      state_d = IDLE;
      beat_d  = '0;
      rr_d    = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
    end
  end

  // grant_id deliberately keeps the last winner in IDLE so data_in stays defined.
  always_comb begin
    bus.ready = '0;
    if (state_q == BURST && !bus.full) bus.ready[grant_q] = 1'b1;
    bus.w_en     = (state_q == BURST) & req_g & ~bus.full;
    bus.data_in  = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    bus.busy     = (state_q == BURST);
    bus.grant_id = grant_q;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a burst-level model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0]  rq;
  logic [DW-1:0] dat [N];
  logic          fl;
  logic [N-1:0]  acc;

  // Model: in a burst or not, owner, beats taken, next-priority index.
  bit mb;
  int mg, mbeats, mrr;

  logic [DW-1:0] dlog[$];
  int            glog[$];
  bit            prev_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply();
    bus.req  = rq;
    bus.full = fl;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = dat[i];
  endtask

  task automatic model_reset();
    mb = 0; mg = 0; mbeats = 0; mrr = 0;
    acc = '0;
    prev_busy = 0;
  endtask

  task automatic model_step();
    if (!mb) begin
      if (rq != '0) begin
        for (int k = 0; k < N; k++) begin
          if (rq[(mrr + k) % N]) begin
            mg = (mrr + k) % N;
            break;
          end
        end
        mbeats = 0;
        mb = 1;
      end
    end else if (!rq[mg] || (!fl && mbeats + 1 == MB)) begin
      mb = 0;
      mrr = (mg + 1) % N;
      mbeats = 0;
    end else if (!fl) begin
      mbeats++;
    end
  endtask

  task automatic cycle(output bit wrote, output bit was_busy);
    logic [N-1:0] erdy;
    bit ew;
    apply();
    @(negedge wclk);
    ew   = mb && rq[mg] && !fl;
    erdy = (mb && !fl) ? (ONE << mg) : '0;
    chk("busy",     32'(bus.busy),     32'(mb));
    chk("grant_id", 32'(bus.grant_id), mg);
    chk("ready",    32'(bus.ready),    32'(erdy));
    chk("w_en",     32'(bus.w_en),     32'(ew));
    chk("data_in",  32'(bus.data_in),  32'(dat[mg]));
    wrote    = (bus.w_en === 1'b1);
    was_busy = (bus.busy === 1'b1);
    if (wrote) dlog.push_back(bus.data_in);
    if (was_busy && !prev_busy) glog.push_back(int'(bus.grant_id));
    prev_busy = was_busy;
    acc = ew ? (ONE << mg) : '0;
    @(posedge wclk);
    model_step();
    #1;
  endtask

  task automatic bump();
    for (int i = 0; i < N; i++) if (acc[i]) dat[i] = dat[i] + 8'd1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    rq = '0;
    fl = 1'b0;
    apply();
    @(posedge wclk);
    #4 wrst_n = 1'b1;
    model_reset();
    dlog.delete();
    glog.delete();
  endtask

  initial begin
    bit w, b;
    int n, n1;
    logic [15:0] wmask, bmask;

    // Reset values
    wrst_n = 1'b0;
    rq = '0; fl = 1'b0;
    dat[0] = 8'h3C; dat[1] = 8'h11; dat[2] = 8'h22; dat[3] = 8'h33;
    apply();
    #2;
    chk("rst_ready",   32'(bus.ready),    0);
    chk("rst_w_en",    32'(bus.w_en),     0);
    chk("rst_busy",    32'(bus.busy),     0);
    chk("rst_grant",   32'(bus.grant_id), 0);
    chk("rst_data_in", 32'(bus.data_in),  32'h3C);
    do_reset();

    // Single requester: two bursts of 4 with one bubble
    rq = 4'b0001; dat[0] = 8'h10; n = 0; wmask = '0;
    for (int c = 0; c < 12; c++) begin
      cycle(w, b);
      if (w) wmask[c] = 1'b1;
      if (acc[0]) begin
        n++;
        if (n == 8) rq[0] = 1'b0; else dat[0] = dat[0] + 8'd1;
      end
    end
    chk("single_wmask", 32'(wmask), 32'h3DE);
    chk("single_count", dlog.size(), 8);
    for (int i = 0; i < 8 && i < dlog.size(); i++) chk("single_data", 32'(dlog[i]), 32'h10 + i);

    // All four held from reset: 0,1,2,3,0
    do_reset();
    rq = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 8'hB0 + 8'(i);
    for (int c = 0; c < 25; c++) cycle(w, b);
    chk("rr_bursts", glog.size(), 5);
    if (glog.size() == 5) begin
      chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1); chk("rr_g2", glog[2], 2);
      chk("rr_g3", glog[3], 3); chk("rr_g4", glog[4], 0);
    end
    chk("rr_beats", dlog.size(), 20);

    // Full stall on requester 2 after beat 1
    do_reset();
    rq = 4'b0100; dat[2] = 8'hA0; n = 0; wmask = '0;
    for (int c = 0; c < 11; c++) begin
      fl = (c >= 3 && c < 8);
      cycle(w, b);
      if (w) wmask[c] = 1'b1;
      if (acc[2]) begin
        n++;
        if (n == 4) rq[2] = 1'b0; else dat[2] = dat[2] + 8'd1;
      end
    end
    fl = 1'b0;
    chk("stall_wmask", 32'(wmask), 32'h306);
    chk("stall_beats", n, 4);
    if (dlog.size() == 4) chk("stall_beat2", 32'(dlog[2]), 32'hA2);
    else chk("stall_count", dlog.size(), 4);

    // Requester 1 withdraws after 2 beats, requester 3 pending
    do_reset();
    rq = 4'b1010; dat[1] = 8'hC0; dat[3] = 8'hD0; n1 = 0; wmask = '0; bmask = '0;
    for (int c = 0; c < 7; c++) begin
      cycle(w, b);
      if (w) wmask[c] = 1'b1;
      if (b) bmask[c] = 1'b1;
      if (c == 3) chk("withdraw_rr_model", mrr, 2);
      if (acc[1]) begin n1++; if (n1 == 2) rq[1] = 1'b0; end
      if (acc[3]) rq[3] = 1'b0;
      bump();
    end
    chk("withdraw_wmask", 32'(wmask), 32'h26);
    chk("withdraw_bmask", 32'(bmask), 32'h6E);
    chk("withdraw_bursts", glog.size(), 2);
    if (glog.size() == 2) chk("withdraw_next", glog[1], 3);
    if (dlog.size() == 3) chk("withdraw_d3", 32'(dlog[2]), 32'hD0);

    // Requester 0 withdraws while stalled on full
    do_reset();
    rq = 4'b0101; dat[0] = 8'hE0; dat[2] = 8'hE2; wmask = '0;
    for (int c = 0; c < 6; c++) begin
      fl = (c == 1 || c == 2);
      if (c == 2) rq[0] = 1'b0;
      cycle(w, b);
      if (w) wmask[c] = 1'b1;
      if (acc[2]) rq[2] = 1'b0;
    end
    fl = 1'b0;
    chk("stallwd_wmask", 32'(wmask), 32'h10);
    chk("stallwd_bursts", glog.size(), 2);
    if (glog.size() == 2) chk("stallwd_next", glog[1], 2);
    if (dlog.size() == 1) chk("stallwd_data", 32'(dlog[0]), 32'hE2);
    else chk("stallwd_count", dlog.size(), 1);

    // Reset mid-burst of requester 1
    do_reset();
    rq = 4'b0111; dat[0] = 8'h20; dat[1] = 8'h30; dat[2] = 8'h40;
    for (int c = 0; c < 7; c++) begin
      cycle(w, b);
      bump();
    end
    chk("pre_rst_grant", 32'(bus.grant_id), 1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(bus.busy),     0);
    chk("mid_rst_w_en",  32'(bus.w_en),     0);
    chk("mid_rst_ready", 32'(bus.ready),    0);
    chk("mid_rst_grant", 32'(bus.grant_id), 0);
    chk("mid_rst_data",  32'(bus.data_in),  32'h24);
    @(negedge wclk);
    chk("in_rst_w_en", 32'(bus.w_en), 0);
    @(posedge wclk);
    #4 wrst_n = 1'b1;
    model_reset();
    glog.delete();
    for (int c = 0; c < 3; c++) begin
      cycle(w, b);
      bump();
    end
    chk("post_rst_bursts", glog.size(), 1);
    if (glog.size() == 1) chk("post_rst_grant", glog[0], 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 750 == 749) do_reset();
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          if (acc[i]) begin
            dat[i] = 8'($urandom);
            rq[i]  = ($urandom_range(3) != 0);
          end else if ($urandom_range(15) == 0) begin
            rq[i] = 1'b0;
          end
        end else if ($urandom_range(2) == 0) begin
          rq[i]  = 1'b1;
          dat[i] = 8'($urandom);
        end
      end
      fl = ($urandom_range(3) == 0);
      cycle(w, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
